// File: rtl/dispatcher.sv
// AXI-S TX dispatcher: drains a show-ahead FIFO onto a NoC TX port as fixed-length packets.
// Optional build macro DISPATCHER_STATS_EN enables the beats_sent/pkts_sent counters.

module fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 512
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wen,
  input  logic [W-1:0] wdata,
  input  logic         ren,
  output logic [W-1:0] odata,
  output logic         empty,
  output logic         almost_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg, rd_addr;
  logic [AW:0]   count_reg, avail_reg;
  logic          wr_pend_reg;
  logic [W-1:0]  odata_reg;
  logic          pop;

  // An entry becomes readable one cycle after its write, so the prefetch
  // read below never races the write port.
  assign pop         = ren && !empty;
  assign rd_addr     = pop ? rptr_reg + 1'b1 : rptr_reg;
  assign empty       = (avail_reg == '0);
  assign almost_full = (count_reg >= (AW+1)'(DEPTH-1));
  assign odata       = odata_reg;

  always_ff @(posedge clk) begin
    if (wen) mem[wptr_reg] <= wdata;
    odata_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg    <= '0;
      rptr_reg    <= '0;
      count_reg   <= '0;
      avail_reg   <= '0;
      wr_pend_reg <= 1'b0;
    end else begin
      wr_pend_reg <= wen;
      if (wen) wptr_reg <= wptr_reg + 1'b1;
      if (pop) rptr_reg <= rptr_reg + 1'b1;
      case ({wen, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      case ({wr_pend_reg, pop})
        2'b10:   avail_reg <= avail_reg + 1'b1;
        2'b01:   avail_reg <= avail_reg - 1'b1;
        default: avail_reg <= avail_reg;
      endcase
    end
  end
endmodule

module dispatcher #(
  parameter int DATAW     = 512,
  parameter int BYTEW     = 8,
  parameter int IDW       = 32,
  parameter int DESTW     = 7,
  parameter int USERW     = 75,
  parameter int DATAUSERW = DATAW + USERW,
  parameter int PKT_BEATS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_fifo_wen,
  input  logic [DATAW-1:0]     data_fifo_wdata,
  output logic                 data_fifo_rdy,
  input  logic [DESTW-1:0]     dest_cfg,
  output logic                 axis_tx_tvalid,
  input  logic                 axis_tx_tready,
  output logic [DATAUSERW-1:0] axis_tx_tdata,
  output logic [BYTEW-1:0]     axis_tx_tstrb,
  output logic [BYTEW-1:0]     axis_tx_tkeep,
  output logic [IDW-1:0]       axis_tx_tid,
  output logic [DESTW-1:0]     axis_tx_tdest,
  output logic [USERW-1:0]     axis_tx_tuser,
  output logic                 axis_tx_tlast,
  output logic [31:0]          beats_sent,
  output logic [31:0]          pkts_sent
);
  localparam int CW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_BEATS - 1);

  typedef enum logic {IDLE, BODY} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    beat_cnt_reg, beat_cnt_next;
  logic [DATAW-1:0] payload_reg, payload_next;
  logic             tvalid_reg, tvalid_next;
  logic             tlast_reg, tlast_next;
  logic [DESTW-1:0] tdest_reg, tdest_next;
  logic [IDW-1:0]   tid_reg, tid_next;
  logic             en_reg;

  logic [DATAW-1:0] fifo_odata;
  logic             fifo_empty, fifo_afull, fifo_push, load, hs;

  // en_reg keeps rdy low for the whole reset window regardless of FIFO state.
  assign data_fifo_rdy = en_reg && !fifo_afull;
  assign fifo_push     = data_fifo_wen && data_fifo_rdy;
  assign load          = !fifo_empty && (!tvalid_reg || axis_tx_tready);
  assign hs            = tvalid_reg && axis_tx_tready;

  fifo #(DATAW, 512) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .wen         (fifo_push),
    .wdata       (data_fifo_wdata),
    .ren         (load),
    .odata       (fifo_odata),
    .empty       (fifo_empty),
    .almost_full (fifo_afull)
  );

  always_comb begin
    state_next    = state_reg;
    beat_cnt_next = beat_cnt_reg;
    payload_next  = payload_reg;
    tvalid_next   = tvalid_reg;
    tlast_next    = tlast_reg;
    tdest_next    = tdest_reg;
    tid_next      = tid_reg;
    if (hs && tlast_reg) tid_next = tid_reg + 1'b1;
    if (load) begin
      tvalid_next  = 1'b1;
      payload_next = fifo_odata;
      case (state_reg)
        IDLE: begin
          tdest_next = dest_cfg;
          if (PKT_BEATS == 1) begin
            tlast_next    = 1'b1;
            beat_cnt_next = '0;
          end else begin
            tlast_next    = 1'b0;
            beat_cnt_next = CW'(1);
            state_next    = BODY;
          end
        end
        default: begin
          if (beat_cnt_reg == LAST_CNT) begin
            tlast_next    = 1'b1;
            beat_cnt_next = '0;
            state_next    = IDLE;
          end else begin
            tlast_next    = 1'b0;
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
      endcase
    end else if (hs) begin
      tvalid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      beat_cnt_reg <= '0;
      payload_reg  <= '0;
      tvalid_reg   <= 1'b0;
      tlast_reg    <= 1'b0;
      tdest_reg    <= '0;
      tid_reg      <= '0;
      en_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      beat_cnt_reg <= beat_cnt_next;
      payload_reg  <= payload_next;
      tvalid_reg   <= tvalid_next;
      tlast_reg    <= tlast_next;
      tdest_reg    <= tdest_next;
      tid_reg      <= tid_next;
      en_reg       <= 1'b1;
    end
  end

  assign axis_tx_tvalid = tvalid_reg;
  assign axis_tx_tdata  = {{USERW{1'b0}}, payload_reg};
  assign axis_tx_tstrb  = '1;
  assign axis_tx_tkeep  = '1;
  assign axis_tx_tid    = tid_reg;
  assign axis_tx_tdest  = tdest_reg;
  assign axis_tx_tuser  = '0;
  assign axis_tx_tlast  = tlast_reg;

`ifdef DISPATCHER_STATS_EN
  logic [31:0] beats_reg, pkts_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_reg <= '0;
      pkts_reg  <= '0;
    end else if (hs) begin
      beats_reg <= beats_reg + 1'b1;
      if (tlast_reg) pkts_reg <= pkts_reg + 1'b1;
    end
  end

  assign beats_sent = beats_reg;
  assign pkts_sent  = pkts_reg;
`else
  assign beats_sent = '0;
  assign pkts_sent  = '0;
`endif
endmodule
